// File: rtl/reflet_mem_arbiter.sv
// Purpose : shares one synchronous RAM port between port 0 (CPU) and port 1 (debug/DMA),
//           adding zero-extended narrow reads and read-modify-write narrow writes.
// Latency : req sampled in IDLE at edge T -> ack at T+2 (full write), T+3 (read), T+4 (narrow write).
// Backpr. : a requester holds req until its one-cycle ack; losers wait, one IDLE cycle between grants.
// Ports   : clk/reset (async active-low); reqN/weN/sizeN/addrN/wdataN in, ackN/rdataN out per port;
//           ram_en/ram_we/ram_addr/ram_wdata to the RAM, ram_rdata back (1-cycle read latency); busy.
module reflet_mem_arbiter #(
  parameter int wordsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic                we0,
  input  logic [1:0]          size0,
  input  logic [wordsize-1:0] addr0,
  input  logic [wordsize-1:0] wdata0,
  output logic                ack0,
  output logic [wordsize-1:0] rdata0,
  input  logic                req1,
  input  logic                we1,
  input  logic [1:0]          size1,
  input  logic [wordsize-1:0] addr1,
  input  logic [wordsize-1:0] wdata1,
  output logic                ack1,
  output logic [wordsize-1:0] rdata1,
  output logic                ram_en,
  output logic                ram_we,
  output logic [wordsize-1:0] ram_addr,
  output logic [wordsize-1:0] ram_wdata,
  input  logic [wordsize-1:0] ram_rdata,
  output logic                busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ACCESS  = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] WRITE   = 3'd3;
  localparam logic [2:0] ACK     = 3'd4;

  logic [2:0]          state;
  logic                port_q;      // granted port
  logic                we_q;
  logic [1:0]          size_q;
  logic [wordsize-1:0] addr_q;
  logic [wordsize-1:0] wdata_q;
  logic [wordsize-1:0] data_q;      // read result or merged write word
  logic                last_grant;

  logic                gnt1;
  int                  width_bits;
  logic                narrow;
  logic [wordsize-1:0] mask;

  // On a tie, the port that did not win last time gets the grant.
  assign gnt1 = req1 & (~req0 | ~last_grant);

  // A width that is not smaller than the word collapses to a full-word access.
  always_comb begin
    case (size_q)
      2'b01:   width_bits = 32;
      2'b10:   width_bits = 16;
      2'b11:   width_bits = 8;
      default: width_bits = wordsize;
    endcase
    narrow = (size_q != 2'b00) && (width_bits < wordsize);
    mask   = '0;
    for (int i = 0; i < wordsize; i++) begin
      mask[i] = narrow ? (i < width_bits) : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            port_q     <= gnt1;
            we_q       <= gnt1 ? we1    : we0;
            size_q     <= gnt1 ? size1  : size0;
            addr_q     <= gnt1 ? addr1  : addr0;
            wdata_q    <= gnt1 ? wdata1 : wdata0;
            last_grant <= gnt1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          state <= (we_q && !narrow) ? ACK : CAPTURE;
        end
        CAPTURE: begin
          // Only reads and narrow writes get here; a full-width read has an all-ones mask.
          if (we_q) begin
            data_q <= (ram_rdata & ~mask) | (wdata_q & mask);
            state  <= WRITE;
          end else begin
            data_q <= ram_rdata & mask;
            state  <= ACK;
          end
        end
        WRITE:   state <= ACK;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so a reset clears them in the same instant.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    case (state)
      ACCESS: begin
        ram_en   = 1'b1;
        ram_addr = addr_q;
        if (we_q && !narrow) begin
          ram_we    = 1'b1;
          ram_wdata = wdata_q;
        end
      end
      WRITE: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = data_q;
      end
      ACK: begin
        if (port_q) begin
          ack1   = 1'b1;
          rdata1 = we_q ? '0 : data_q;
        end else begin
          ack0   = 1'b1;
          rdata0 = we_q ? '0 : data_q;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
